// File: rtl/apb_slave_regfile_if.sv
// APB bus bundle (8-bit address/data) between the requester stage and the register-file completer.
interface apb_slave_regfile_if;
  logic       PSEL;
  logic       PENABLE;
  logic       PWRITE;
  logic [7:0] PADDR;
  logic [7:0] PWDATA;
  logic [7:0] PRDATA;
  logic       PREADY;
  logic       PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_slave_regfile.sv
// APB completer: DEPTH x 8-bit register file, wait-state insertion and error response for out-of-range addresses.
// Optional APB_SLV_PROG_WAIT_EN adds a wait-config register at address 8'hFF.
module apb_slave_regfile #(
  parameter int         DEPTH       = 16,
  parameter int         WAIT_CYCLES = 1,
  parameter logic [7:0] RESET_VAL   = 8'h00
) (
  input  logic                PCLK,
  input  logic                PRESET,
  apb_slave_regfile_if.slave  bus
);
  localparam int         AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [7:0] CFG_ADDR = 8'hFF;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_e;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] addr_q, wdata_q;
  logic       wr_q, err_q;
  logic [7:0] mem_q [DEPTH];
  logic       prdy_q, prdy_d, perr_q, perr_d;
  logic [7:0] prdata_q, prdata_d;
  logic [3:0] wait_cfg;
  logic       addr_err, setup, commit, mem_we;
  logic [7:0] rd_word;
  logic [AW-1:0] idx;

  assign setup  = bus.PSEL & ~bus.PENABLE;
  assign commit = (state_q == DONE) & wr_q & ~err_q;
  assign idx    = addr_q[AW-1:0];

`ifdef APB_SLV_PROG_WAIT_EN
  logic [3:0] wait_cfg_q;
  logic       is_cfg;

  // A zero wait count would underflow the reload, so it is clamped to one.
  function automatic logic [3:0] clamp_wait(input logic [3:0] d);
    return (d == 4'd0) ? 4'd1 : d;
  endfunction

  assign is_cfg   = (addr_q == CFG_ADDR);
  assign wait_cfg = wait_cfg_q;
  assign addr_err = (bus.PADDR >= 8'(DEPTH)) && (bus.PADDR != CFG_ADDR);
  assign mem_we   = commit & ~is_cfg;
  assign rd_word  = is_cfg ? {4'h0, wait_cfg_q}
                  : ((addr_q < 8'(DEPTH)) ? mem_q[idx] : 8'h00);

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET)               wait_cfg_q <= 4'(WAIT_CYCLES);
    else if (commit && is_cfg) wait_cfg_q <= clamp_wait(wdata_q[3:0]);
  end
`else
  assign wait_cfg = 4'(WAIT_CYCLES);
  assign addr_err = (bus.PADDR >= 8'(DEPTH));
  assign mem_we   = commit;
  assign rd_word  = (addr_q < 8'(DEPTH)) ? mem_q[idx] : 8'h00;
`endif

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (setup) begin
        state_d = WAIT;
        cnt_d   = wait_cfg - 4'd1;
      end
      WAIT: begin
        if (!bus.PSEL)         state_d = IDLE;
        else if (bus.PENABLE) begin
          if (cnt_q == 4'd0)   state_d = DONE;
          else                 cnt_d   = cnt_q - 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered, so they are decoded from the state being entered.
  always_comb begin
    prdy_d   = (state_d == DONE);
    perr_d   = (state_d == DONE) & err_q;
    prdata_d = 8'h00;
    if (state_d == DONE && !wr_q && !err_q) prdata_d = rd_word;
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      prdy_q   <= 1'b0;
      perr_q   <= 1'b0;
      prdata_q <= 8'h00;
    end else begin
      prdy_q   <= prdy_d;
      perr_q   <= perr_d;
      prdata_q <= prdata_d;
    end
  end

  // Transfer attributes are captured once at setup and held, so later bus changes are ignored.
  always_ff @(posedge PCLK) begin
    if (state_q == IDLE && setup) begin
      addr_q  <= bus.PADDR;
      wdata_q <= bus.PWDATA;
      wr_q    <= bus.PWRITE;
      err_q   <= addr_err;
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= RESET_VAL;
    end else if (mem_we) begin
      mem_q[idx] <= wdata_q;
    end
  end

  assign bus.PREADY  = prdy_q;
  assign bus.PSLVERR = perr_q;
  assign bus.PRDATA  = prdata_q;
endmodule

// File: tb/tb_apb_slave_regfile.sv
// Scoreboard bench for apb_slave_regfile: expected completions are queued at setup and checked on PREADY.
module tb_apb_slave_regfile;
  localparam int DEPTH       = 16;
  localparam int WAIT_CYCLES = 1;

  logic PCLK;
  logic PRESET;

  apb_slave_regfile_if bus();

  apb_slave_regfile #(
    .DEPTH(DEPTH), .WAIT_CYCLES(WAIT_CYCLES), .RESET_VAL(8'h00)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET), .bus(bus)
  );

  typedef struct packed {
    logic       err;
    logic [7:0] rd;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk    = 0;
  int   n_err    = 0;
  int   cur_wait = WAIT_CYCLES;

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Completion monitor: every PREADY pulse consumes one queued expectation.
  always @(negedge PCLK) begin
    exp_t e;
    if (!PRESET) begin
      if (bus.PREADY) begin
        if (sb_q.size() == 0) chk("unexpected_pready", 1, 0);
        else begin
          e = sb_q.pop_front();
          chk("pslverr", bus.PSLVERR, e.err);
          chk("prdata", bus.PRDATA, e.rd);
        end
      end else begin
        chk("idle_pslverr", bus.PSLVERR, 0);
        chk("idle_prdata", bus.PRDATA, 0);
      end
    end
  end

  // Full transfer; returns in the completion cycle with the bus still in the access phase.
  task automatic xfer(input logic wr, input logic [7:0] a, input logic [7:0] d,
                      input logic e, input logic [7:0] rd);
    int   n;
    exp_t x;
    x.err = e;
    x.rd  = rd;
    sb_q.push_back(x);
    @(posedge PCLK); #1;
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = wr; bus.PADDR = a; bus.PWDATA = d;
    @(negedge PCLK);
    chk("setup_pready", bus.PREADY, 0);
    @(posedge PCLK); #1;
    bus.PENABLE = 1'b1;
    n = 0;
    do begin
      @(negedge PCLK);
      n++;
    end while (!bus.PREADY && n < 40);
    chk("latency", n, cur_wait + 1);
  endtask

  task automatic idle();
    @(posedge PCLK); #1;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
  endtask

  initial begin
    PRESET = 1'b1;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
    bus.PADDR = 8'h00; bus.PWDATA = 8'h00;
    repeat (2) @(posedge PCLK);
    #1;
    chk("rst_pready", bus.PREADY, 0);
    chk("rst_prdata", bus.PRDATA, 0);
    chk("rst_pslverr", bus.PSLVERR, 0);
    PRESET = 1'b0;

    xfer(1'b1, 8'h03, 8'hA5, 1'b0, 8'h00); idle();
    xfer(1'b0, 8'h03, 8'h00, 1'b0, 8'hA5); idle();

    xfer(1'b1, 8'h20, 8'h5A, 1'b1, 8'h00); idle();
    xfer(1'b0, 8'h00, 8'h00, 1'b0, 8'h00); idle();
`ifdef APB_SLV_PROG_WAIT_EN
    xfer(1'b0, 8'hFF, 8'h00, 1'b0, 8'(cur_wait)); idle();
`else
    xfer(1'b0, 8'hFF, 8'h00, 1'b1, 8'h00); idle();
`endif

    xfer(1'b1, 8'h01, 8'h11, 1'b0, 8'h00);
    xfer(1'b0, 8'h01, 8'h00, 1'b0, 8'h11); idle();

    // Abandoned transfer: PSEL drops right after setup.
    @(posedge PCLK); #1;
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1; bus.PADDR = 8'h04; bus.PWDATA = 8'h77;
    @(posedge PCLK); #1;
    bus.PSEL = 1'b0;
    repeat (5) begin
      @(negedge PCLK);
      chk("abort_pready", bus.PREADY, 0);
    end
    xfer(1'b0, 8'h04, 8'h00, 1'b0, 8'h00); idle();

    // Reset during the wait phase of a write.
    xfer(1'b1, 8'h02, 8'h33, 1'b0, 8'h00); idle();
    @(posedge PCLK); #1;
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1; bus.PADDR = 8'h02; bus.PWDATA = 8'h55;
    @(posedge PCLK); #1;
    bus.PENABLE = 1'b1;
    #2 PRESET = 1'b1;
    #1 chk("rst_wait_pready", bus.PREADY, 0);
    @(posedge PCLK); #1;
    PRESET = 1'b0; bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
    xfer(1'b0, 8'h02, 8'h00, 1'b0, 8'h00); idle();

    // Reset during a completion cycle clears outputs without waiting for a clock.
    xfer(1'b1, 8'h05, 8'hC3, 1'b0, 8'h00); idle();
    xfer(1'b0, 8'h05, 8'h00, 1'b0, 8'hC3);
    #2 PRESET = 1'b1;
    #1;
    chk("rst_done_pready", bus.PREADY, 0);
    chk("rst_done_prdata", bus.PRDATA, 0);
    @(posedge PCLK); #1;
    PRESET = 1'b0; bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
    xfer(1'b0, 8'h05, 8'h00, 1'b0, 8'h00); idle();
    xfer(1'b0, 8'h03, 8'h00, 1'b0, 8'h00); idle();

`ifdef APB_SLV_PROG_WAIT_EN
    xfer(1'b1, 8'hFF, 8'h04, 1'b0, 8'h00); idle();
    cur_wait = 4;
    xfer(1'b0, 8'h03, 8'h00, 1'b0, 8'h00); idle();
    xfer(1'b0, 8'hFF, 8'h00, 1'b0, 8'h04); idle();
    xfer(1'b1, 8'hFF, 8'h00, 1'b0, 8'h00); idle();
    cur_wait = 1;
    xfer(1'b0, 8'hFF, 8'h00, 1'b0, 8'h01); idle();
`endif

    repeat (3) @(posedge PCLK);
    chk("sb_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
